// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared definitions for the counter_193_sync block:
//               - default counter width and its terminal values
//               - the per-cycle action decoded by the counter datapath
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Default counter / preset width in bits.
  localparam int CNT_WIDTH = 4;

  // Terminal values at the default width: all-ones ends an up count and
  // zero ends a down count.
  localparam logic [CNT_WIDTH-1:0] CNT_ALL_ONES = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = '0;

  // Action selected for the counter register on a given clock edge,
  // already resolved by priority (clear > load > count > hold).
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_UP    = 3'd3,
    OP_DOWN  = 3'd4
  } cnt_op_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_193_sync_rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : Single-bit registered rising-edge detector. The previous-
//               cycle copy of the input resets to 1, so an input that is
//               already high when reset is released never looks like a
//               fresh low-to-high transition.
// Ports       : clk    - system clock, rising edge
//               rst    - synchronous active-high reset
//               i_d    - sampled level
//               o_rise - high for the cycle in which i_d is 1 and was 0
//                        on the previous clock
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // Loads every cycle; nothing else in the design can stall it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule : rise_detect
`default_nettype wire

// File: rtl/counter_193_sync.sv
`default_nettype none
// ============================================================================
// Module      : counter_193_sync
// Description : Single-clock-domain model of a 74x193 presettable binary
//               up/down counter. Count strobes are sampled on clk and
//               edge-detected internally; clear and parallel load are
//               synchronous. Terminal-count outputs are active low and are
//               formed from the registered count and the live strobes so
//               that stages can be cascaded the way the discrete part is.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               clr  - functional clear, active high
//               npl  - parallel load, active low
//               p    - preset data [WIDTH-1:0]
//               cpu  - count-up strobe, counts on its rising transition
//               cpd  - count-down strobe, counts on its rising transition
//               q    - registered count [WIDTH-1:0]
//               ntcu - carry, low while q is all-ones and cpu is low
//               ntcd - borrow, low while q is zero and cpd is low
// Revision    : 1.0 - initial release
// ============================================================================
module counter_193_sync
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             npl,
  input  logic [WIDTH-1:0] p,
  input  logic             cpu,
  input  logic             cpd,
  output logic [WIDTH-1:0] q,
  output logic             ntcu,
  output logic             ntcd
);

  localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
  localparam logic [WIDTH-1:0] c_ZERO     = '0;
  localparam logic [WIDTH-1:0] c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             w_up_edge;
  logic             w_dn_edge;
  cnt_op_e          w_op;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] r_q;

  // --------------------------------------------------------------------------
  // Strobe edge detection
  // --------------------------------------------------------------------------
  rise_detect u_rise_cpu (
    .clk    (clk),
    .rst    (rst),
    .i_d    (cpu),
    .o_rise (w_up_edge)
  );

  rise_detect u_rise_cpd (
    .clk    (clk),
    .rst    (rst),
    .i_d    (cpd),
    .o_rise (w_dn_edge)
  );

  // --------------------------------------------------------------------------
  // Action decode
  // An up edge only counts while cpd is held high and a down edge only
  // while cpu is held high, as on the discrete part. When both strobes rise
  // in the same cycle both inhibits are released at once; that case is
  // resolved as "no count" rather than letting one direction win.
  // --------------------------------------------------------------------------
  always_comb begin
    w_op = OP_HOLD;
    if (clr) begin
      w_op = OP_CLEAR;
    end else if (!npl) begin
      w_op = OP_LOAD;
    end else if (w_up_edge && w_dn_edge) begin
      w_op = OP_HOLD;
    end else if (w_up_edge && cpd) begin
      w_op = OP_UP;
    end else if (w_dn_edge && cpu) begin
      w_op = OP_DOWN;
    end
  end

  // --------------------------------------------------------------------------
  // Next-count datapath; arithmetic wraps naturally at WIDTH bits.
  // --------------------------------------------------------------------------
  always_comb begin
    w_q_next = r_q;
    case (w_op)
      OP_CLEAR: w_q_next = c_ZERO;
      OP_LOAD:  w_q_next = p;
      OP_UP:    w_q_next = r_q + c_ONE;
      OP_DOWN:  w_q_next = r_q - c_ONE;
      default:  w_q_next = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= c_ZERO;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

  // --------------------------------------------------------------------------
  // Terminal-count outputs. These deliberately see the live strobe rather
  // than a registered copy: at the terminal value the output follows the
  // strobe, so a downstream stage's strobe input gets a rising edge exactly
  // when this stage's strobe returns high and the count wraps.
  // --------------------------------------------------------------------------
  assign ntcu = ~(~cpu && (r_q == c_ALL_ONES));
  assign ntcd = ~(~cpd && (r_q == c_ZERO));

endmodule : counter_193_sync
`default_nettype wire

// File: tb/tb_counter_193_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_193_sync
// Description : Self-checking bench for counter_193_sync. A behavioural
//               reference model predicts q/ntcu/ntcd for every clock; the
//               prediction is queued when stimulus is applied and compared
//               against the DUT just after the following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_193_sync;
  import counter_pkg::*;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] q;
    logic                 ntcu;
    logic                 ntcd;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 clr;
  logic                 npl;
  logic [CNT_WIDTH-1:0] p;
  logic                 cpu;
  logic                 cpd;
  logic [CNT_WIDTH-1:0] q;
  logic                 ntcu;
  logic                 ntcd;

  // Reference model state
  logic [CNT_WIDTH-1:0] m_q;
  logic                 m_cpu_d;
  logic                 m_cpd_d;

  exp_t sb_q[$];
  int   n_total;
  int   n_bad;

  counter_193_sync #(.WIDTH(CNT_WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .npl  (npl),
    .p    (p),
    .cpu  (cpu),
    .cpd  (cpd),
    .q    (q),
    .ntcu (ntcu),
    .ntcd (ntcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // One clock: predict from the model and current stimulus, queue the
  // prediction, clock the DUT, then pop and compare.
  task automatic tick();
    exp_t                 e;
    logic [CNT_WIDTH-1:0] nq;
    logic                 up;
    logic                 dn;
    up = cpu & ~m_cpu_d;
    dn = cpd & ~m_cpd_d;
    if (rst)               nq = '0;
    else if (clr)          nq = '0;
    else if (!npl)         nq = p;
    else if (up && dn)     nq = m_q;
    else if (up && cpd)    nq = m_q + 4'd1;
    else if (dn && cpu)    nq = m_q - 4'd1;
    else                   nq = m_q;
    m_cpu_d = rst ? 1'b1 : cpu;
    m_cpd_d = rst ? 1'b1 : cpd;
    m_q     = nq;
    e.q    = nq;
    e.ntcu = ~(~cpu && (nq == CNT_ALL_ONES));
    e.ntcd = ~(~cpd && (nq == CNT_ZERO));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      chk("q",    {4'd0, q},    {4'd0, e.q});
      chk("ntcu", {7'd0, ntcu}, {7'd0, e.ntcu});
      chk("ntcd", {7'd0, ntcd}, {7'd0, e.ntcd});
    end
  endtask

  task automatic pulse_up(input int n);
    for (int i = 0; i < n; i++) begin
      cpu = 1'b0; tick(); tick();
      cpu = 1'b1; tick(); tick();
    end
  endtask

  task automatic pulse_dn(input int n);
    for (int i = 0; i < n; i++) begin
      cpd = 1'b0; tick(); tick();
      cpd = 1'b1; tick(); tick();
    end
  endtask

  task automatic load(input logic [CNT_WIDTH-1:0] v);
    npl = 1'b0; p = v; tick();
    npl = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_q     = '0;
    m_cpu_d = 1'b1;
    m_cpd_d = 1'b1;
    rst = 1'b1; clr = 1'b0; npl = 1'b1; p = '0; cpu = 1'b1; cpd = 1'b1;

    // Reset
    tick(); tick();
    chk("rst_q",    {4'd0, q},    8'h00);
    chk("rst_ntcu", {7'd0, ntcu}, 8'h01);
    chk("rst_ntcd", {7'd0, ntcd}, 8'h01);
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_q", {4'd0, q}, 8'h00);

    // Count up with wrap
    pulse_up(1);
    chk("up1_q", {4'd0, q}, 8'h01);
    pulse_up(14);
    chk("up15_q", {4'd0, q}, 8'h0F);
    cpu = 1'b0; tick();
    chk("tcu_low", {7'd0, ntcu}, 8'h00);
    tick();
    cpu = 1'b1; tick(); tick();
    chk("up16_q", {4'd0, q}, 8'h00);
    pulse_up(1);
    chk("up17_q", {4'd0, q}, 8'h01);

    // Count down with wrap
    load(4'b0010);
    pulse_dn(1);
    chk("dn1_q", {4'd0, q}, 8'h01);
    pulse_dn(1);
    chk("dn2_q", {4'd0, q}, 8'h00);
    cpd = 1'b0; tick();
    chk("tcd_low", {7'd0, ntcd}, 8'h00);
    tick();
    cpd = 1'b1; tick(); tick();
    chk("dn3_q", {4'd0, q}, 8'h0F);

    // Load and clear priority
    npl = 1'b0; p = 4'b1101; tick();
    chk("load_q", {4'd0, q}, 8'h0D);
    pulse_up(32);
    chk("load_hold_q", {4'd0, q}, 8'h0D);
    p = 4'b1111; tick();
    pulse_up(2);
    clr = 1'b1; p = 4'b1010;
    pulse_dn(2);
    chk("clr_q", {4'd0, q}, 8'h00);
    clr = 1'b0; npl = 1'b1;

    // Inhibit and simultaneous edges
    load(4'b0110);
    cpd = 1'b0; tick();
    pulse_up(32);
    chk("inh_up_q", {4'd0, q}, 8'h06);
    cpu = 1'b0; tick();
    pulse_dn(32);
    chk("inh_dn_q", {4'd0, q}, 8'h06);
    cpu = 1'b0; cpd = 1'b0; tick(); tick();
    cpu = 1'b1; cpd = 1'b1; tick();
    chk("simul_q", {4'd0, q}, 8'h06);
    tick();

    // Sweep of clr/npl/preset combinations followed by mixed strobe trains
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v   = i[5:0];
      clr = v[5]; npl = v[4]; p = v[3:0];
      cpu = 1'b1; cpd = 1'b1;
      tick(); tick();
      clr = 1'b0; npl = 1'b1;
      pulse_up(1);
      pulse_dn(1);
      cpd = 1'b0; pulse_up(1);
      cpu = 1'b0; pulse_dn(1);
      cpu = 1'b1; tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_counter_193_sync
`default_nettype wire
